rotating_square_sseg_param: RTL and testbench
=============================================

Name: rotating_square_sseg_param

Overview:
Parametrised rotating-square animator for an N-digit multiplexed seven-segment display.
- A single square travels along the top half of the digits, then back along the bottom half, giving a closed loop of 2*NUM_DIGITS positions.
- An internal prescaler sets the animation speed. The block supports direction control, enable, a single-step input and a wrap indicator.
- It sits between the board clock/switch inputs and the sseg/digit-select pins.

Parameters:
NUM_DIGITS, 4, number of display digits, legal range 2..8
STEP_DIV, 50000000, clock cycles per animation step, minimum 1

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous, active-high reset
i_en  input  1  1 = prescaler runs and auto-advances the animation
i_cw  input  1  direction: 1 = increment position, 0 = decrement position
i_step  input  1  single-cycle pulse; advances the animation one position, regardless of i_en
o_sseg_n  output  8  segment pattern, active-low, bit order {dp,g,f,e,d,c,b,a}
o_ldsel  output  NUM_DIGITS  one-hot digit select, active-high; MSB is the leftmost digit
o_wrap  output  1  one-cycle pulse when the position wraps

Behaviour:
- Prescaler: counter of width clog2(STEP_DIV), or 1 bit when STEP_DIV=1.
  - When i_en=1: counts 0..STEP_DIV-1 and wraps to 0. tick=1 in the cycle where the count equals STEP_DIV-1.
  - When i_en=0: holds its value and tick=0.
  - STEP_DIV=1: tick=1 every cycle while i_en=1.
- Position register p: range 0..2*NUM_DIGITS-1, width clog2(2*NUM_DIGITS).
  - Advance condition: adv = tick | i_step. Simultaneous tick and i_step advance by exactly one position.
  - On adv with i_cw=1: p <= (p == 2N-1) ? 0 : p+1.
  - On adv with i_cw=0: p <= (p == 0) ? 2N-1 : p-1.
  - No adv: p holds.
- o_wrap: registered.
  - Asserted for one cycle following an advance from 2N-1 to 0 (cw) or from 0 to 2N-1 (ccw).
  - 0 otherwise.
- Decode: combinational from p, so outputs change in the same cycle p updates. Latency from the adv cycle to the visible output is one clock.
  - p < N: o_sseg_n = 8'b10011100 (upper square); o_ldsel bit (N-1-p) = 1, so the square moves left to right.
  - p >= N: o_sseg_n = 8'b10100011 (lower square); o_ldsel bit (p-N) = 1, so the square moves right to left.
  - Exactly one o_ldsel bit is ever set (except when blanked, see Optional Feature).
- Reset (async, any time, mid-step included): prescaler=0, p=0, o_wrap=0. Outputs immediately become o_sseg_n=8'b10011100 with o_ldsel MSB only set.
- Changing i_cw between ticks takes effect at the next advance. No glitch, no skipped position.
- Holding i_step high for k cycles gives k advances. The block does no edge detection; the caller supplies pulses.

Optional Feature:
Macro ROTSQ_BRIGHTNESS_EN.
- Defined:
  - Adds port i_bright (input, 4 bits).
  - Adds a free-running 4-bit PWM counter, reset to 0.
  - o_ldsel is forced to all zeros whenever pwm_cnt >= i_bright.
  - i_bright=0 blanks the display; i_bright=15 gives 15/16 duty.
  - o_sseg_n and o_wrap are unaffected.
- Undefined: no i_bright port, no PWM counter, and o_ldsel is always driven by the decode.

Test Plan:
1. Reset scenario (N=4, STEP_DIV=4): pulse i_rst asynchronously, with no clock edge in between -> o_sseg_n=10011100, o_ldsel=1000, o_wrap=0 immediately.
2. Full clockwise loop: i_en=1, i_cw=1 from reset.
   - p advances every 4 cycles.
   - After 16 cycles: o_sseg_n=10100011, o_ldsel=0001.
   - After 32 cycles: back to 10011100/1000, with o_wrap high for exactly 1 cycle.
3. Counter-clockwise start: i_en=1, i_cw=0 from reset -> first tick gives o_sseg_n=10100011, o_ldsel=1000, and o_wrap pulses once.
4. Single-step and coincidence:
   - i_en=0, three i_step pulses with i_cw=1 -> o_ldsel=0001, upper pattern; prescaler value unchanged.
   - Then i_en=1 with i_step asserted on the tick cycle -> exactly one advance (lower, o_ldsel=0001).
5. Wider display: N=6, STEP_DIV=1, i_en=1, i_cw=1.
   - p=6 -> o_ldsel=000001 lower.
   - p=11 -> o_ldsel=100000 lower.
   - Next cycle o_wrap=1 and o_ldsel=100000 upper.
6. Brightness (ROTSQ_BRIGHTNESS_EN defined):
   - i_bright=4 -> o_ldsel non-zero in exactly 4 of every 16 cycles.
   - i_bright=0 -> o_ldsel constantly 0, while o_sseg_n still animates.

Source files
------------

// File: rtl/rotating_square_sseg_param.sv
// rotating_square_sseg_param
//
// Rotating-square animator for an N-digit multiplexed seven-segment display.
// A single square runs left to right across the upper half of the digits and
// then right to left across the lower half. This forms a closed loop of
// 2*NUM_DIGITS positions. A prescaler sets the animation speed. A single-step
// input advances one position on demand, independent of the prescaler.
//
// Optional feature: define ROTSQ_BRIGHTNESS_EN to add the i_bright port. This
// adds a 4-bit PWM counter that blanks o_ldsel whenever pwm_cnt >= i_bright.
//
// Parameters:
//   NUM_DIGITS  number of display digits (2..8)
//   STEP_DIV    clock cycles per animation step (>= 1)
//
// Ports:
//   i_clk     system clock
//   i_rst     asynchronous active-high reset
//   i_en      1 = prescaler runs and auto-advances the animation
//   i_cw      1 = increment position, 0 = decrement position
//   i_step    advance one position per cycle held high (no edge detect)
//   i_bright  (ROTSQ_BRIGHTNESS_EN only) 4-bit brightness, 0 = blank
//   o_sseg_n  active-low segments {dp,g,f,e,d,c,b,a}
//   o_ldsel   one-hot active-high digit select, MSB = leftmost digit
//   o_wrap    one-cycle pulse after the position wraps in either direction

module rotating_square_sseg_param #(
    parameter int NUM_DIGITS = 4,
    parameter int STEP_DIV   = 50000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_cw,
    input  logic                  i_step,
`ifdef ROTSQ_BRIGHTNESS_EN
    input  logic [3:0]            i_bright,
`endif
    output logic [7:0]            o_sseg_n,
    output logic [NUM_DIGITS-1:0] o_ldsel,
    output logic                  o_wrap
);

    localparam int PW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int POSW = $clog2(2 * NUM_DIGITS);

    localparam logic [PW-1:0]   PS_LAST = PW'(STEP_DIV - 1);
    localparam logic [POSW-1:0] P_LAST  = POSW'(2 * NUM_DIGITS - 1);

    localparam logic [7:0] SEG_UPPER = 8'b10011100;
    localparam logic [7:0] SEG_LOWER = 8'b10100011;

    logic [PW-1:0]         ps_q, ps_d;
    logic [POSW-1:0]       p_q, p_d;
    logic                  wrap_q, wrap_d;
    logic                  tick;
    logic                  adv;
    logic                  upper;
    logic [NUM_DIGITS-1:0] ldsel_dec;

    // Prescaler. With STEP_DIV=1 the terminal count is 0, so tick fires
    // every enabled cycle and the counter stays at 0.
    assign tick = i_en && (ps_q == PS_LAST);

    always_comb begin
        ps_d = ps_q;
        if (i_en) begin
            ps_d = tick ? '0 : ps_q + 1'b1;
        end
    end

    // A tick and a step in the same cycle merge into a single advance.
    assign adv = tick | i_step;

    always_comb begin
        p_d    = p_q;
        wrap_d = 1'b0;
        if (adv) begin
            if (i_cw) begin
                if (p_q == P_LAST) begin
                    p_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    p_d = p_q + 1'b1;
                end
            end else begin
                if (p_q == '0) begin
                    p_d    = P_LAST;
                    wrap_d = 1'b1;
                end else begin
                    p_d = p_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ps_q   <= '0;
            p_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            p_q    <= p_d;
            wrap_q <= wrap_d;
        end
    end

    // Decode. Upper half: digit bit N-1-p, so the square moves left to right.
    // Lower half: digit bit p-N, so the square moves right to left.
    assign upper = (int'(p_q) < NUM_DIGITS);

    always_comb begin
        ldsel_dec = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (upper) begin
                ldsel_dec[i] = (int'(p_q) == NUM_DIGITS - 1 - i);
            end else begin
                ldsel_dec[i] = (int'(p_q) == NUM_DIGITS + i);
            end
        end
    end

    assign o_sseg_n = upper ? SEG_UPPER : SEG_LOWER;
    assign o_wrap   = wrap_q;

`ifdef ROTSQ_BRIGHTNESS_EN
    logic [3:0] pwm_q, pwm_d;

    assign pwm_d = pwm_q + 4'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    // Digits are lit only while the free-running counter is below i_bright.
    assign o_ldsel = (pwm_q < i_bright) ? ldsel_dec : '0;
`else
    assign o_ldsel = ldsel_dec;
`endif

endmodule

// File: tb/tb_rotating_square_sseg_param.sv
module tb_rotating_square_sseg_param;

    localparam logic [7:0] UP = 8'b10011100;
    localparam logic [7:0] LO = 8'b10100011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: N=4, STEP_DIV=4
    logic       rst, en, cw, step;
    logic [7:0] sseg;
    logic [3:0] ld;
    logic       wrap;

    // DUT B: N=6, STEP_DIV=1
    logic       rst6, en6, cw6, step6;
    logic [7:0] sseg6;
    logic [5:0] ld6;
    logic       wrap6;

    int n_asserts = 0;
    int n_fail    = 0;
    int cnt;

`ifdef ROTSQ_BRIGHTNESS_EN
    logic [3:0] bright, bright6;
    logic [3:0] pwm_m, pwm6_m;

    // Reference brightness counters, free running from reset.
    always @(posedge clk or posedge rst)
        if (rst) pwm_m <= 4'd0; else pwm_m <= pwm_m + 4'd1;
    always @(posedge clk or posedge rst6)
        if (rst6) pwm6_m <= 4'd0; else pwm6_m <= pwm6_m + 4'd1;
`endif

    rotating_square_sseg_param #(.NUM_DIGITS(4), .STEP_DIV(4)) u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en     (en),
        .i_cw     (cw),
        .i_step   (step),
`ifdef ROTSQ_BRIGHTNESS_EN
        .i_bright (bright),
`endif
        .o_sseg_n (sseg),
        .o_ldsel  (ld),
        .o_wrap   (wrap)
    );

    rotating_square_sseg_param #(.NUM_DIGITS(6), .STEP_DIV(1)) u_dut6 (
        .i_clk    (clk),
        .i_rst    (rst6),
        .i_en     (en6),
        .i_cw     (cw6),
        .i_step   (step6),
`ifdef ROTSQ_BRIGHTNESS_EN
        .i_bright (bright6),
`endif
        .o_sseg_n (sseg6),
        .o_ldsel  (ld6),
        .o_wrap   (wrap6)
    );

    // Expected digit select, with blanking applied when brightness is built in.
    function automatic logic [3:0] eld(input logic [3:0] v);
`ifdef ROTSQ_BRIGHTNESS_EN
        return (pwm_m < bright) ? v : 4'b0000;
`else
        return v;
`endif
    endfunction

    function automatic logic [5:0] eld6(input logic [5:0] v);
`ifdef ROTSQ_BRIGHTNESS_EN
        return (pwm6_m < bright6) ? v : 6'b000000;
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse that does not straddle a clock edge.
    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cw = 1'b1; step = 1'b0;
        rst6 = 1'b1; en6 = 1'b0; cw6 = 1'b1; step6 = 1'b0;
`ifdef ROTSQ_BRIGHTNESS_EN
        bright = 4'd15; bright6 = 4'd15;
`endif
        cyc(1);
        check("reset_sseg", {8'h0, sseg}, {8'h0, UP});
        check("reset_ldsel", {12'h0, ld}, {12'h0, eld(4'b1000)});
        check("reset_wrap", {15'h0, wrap}, 16'h0);

        // Full clockwise loop
        rst = 1'b0; en = 1'b1; cw = 1'b1;
        cyc(16);
        check("cw16_sseg", {8'h0, sseg}, {8'h0, LO});
        check("cw16_ldsel", {12'h0, ld}, {12'h0, eld(4'b0001)});
        cyc(15);
        check("cw31_ldsel", {12'h0, ld}, {12'h0, eld(4'b1000)});
        check("cw31_sseg", {8'h0, sseg}, {8'h0, LO});
        check("cw31_wrap", {15'h0, wrap}, 16'h0);
        cyc(1);
        check("cw32_sseg", {8'h0, sseg}, {8'h0, UP});
        check("cw32_ldsel", {12'h0, ld}, {12'h0, eld(4'b1000)});
        check("cw32_wrap", {15'h0, wrap}, 16'h1);
        cyc(1);
        check("cw33_wrap", {15'h0, wrap}, 16'h0);
        cyc(8);
        check("cw41_ldsel", {12'h0, ld}, {12'h0, eld(4'b0010)});

        // Asynchronous reset mid-step, observed without a clock edge
        rst = 1'b1;
        #1;
        check("arst_sseg", {8'h0, sseg}, {8'h0, UP});
        check("arst_ldsel", {12'h0, ld}, {12'h0, eld(4'b1000)});
        check("arst_wrap", {15'h0, wrap}, 16'h0);
        #1;
        rst = 1'b0;
        cyc(3);
        check("arst_ps_held", {12'h0, ld}, {12'h0, eld(4'b1000)});
        cyc(1);
        check("arst_first_tick", {12'h0, ld}, {12'h0, eld(4'b0100)});

        // Counter-clockwise start
        cw = 1'b0;
        pulse_rst();
        cyc(3);
        check("ccw3_ldsel", {12'h0, ld}, {12'h0, eld(4'b1000)});
        check("ccw3_wrap", {15'h0, wrap}, 16'h0);
        cyc(1);
        check("ccw4_sseg", {8'h0, sseg}, {8'h0, LO});
        check("ccw4_ldsel", {12'h0, ld}, {12'h0, eld(4'b1000)});
        check("ccw4_wrap", {15'h0, wrap}, 16'h1);
        cyc(1);
        check("ccw5_wrap", {15'h0, wrap}, 16'h0);

        // Single step with prescaler held, then step coinciding with tick
        en = 1'b0; cw = 1'b1;
        pulse_rst();
        repeat (3) begin
            step = 1'b1; cyc(1);
            step = 1'b0; cyc(1);
        end
        check("step3_sseg", {8'h0, sseg}, {8'h0, UP});
        check("step3_ldsel", {12'h0, ld}, {12'h0, eld(4'b0001)});
        en = 1'b1;
        cyc(3);
        check("step_ps_unchanged", {12'h0, ld}, {12'h0, eld(4'b0001)});
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        check("coinc_sseg", {8'h0, sseg}, {8'h0, LO});
        check("coinc_ldsel", {12'h0, ld}, {12'h0, eld(4'b0001)});
        cyc(1);
        check("coinc_single_adv", {12'h0, ld}, {12'h0, eld(4'b0001)});
        en = 1'b0;
        step = 1'b1;
        cyc(2);
        step = 1'b0;
        check("step_hold2", {12'h0, ld}, {12'h0, eld(4'b0100)});
        check("step_hold2_wrap", {15'h0, wrap}, 16'h0);

        // Wider display, one step per cycle
        en6 = 1'b1; cw6 = 1'b1;
        rst6 = 1'b0;
        cyc(6);
        check("n6_p6_sseg", {8'h0, sseg6}, {8'h0, LO});
        check("n6_p6_ldsel", {10'h0, ld6}, {10'h0, eld6(6'b000001)});
        check("n6_p6_wrap", {15'h0, wrap6}, 16'h0);
        cyc(5);
        check("n6_p11_sseg", {8'h0, sseg6}, {8'h0, LO});
        check("n6_p11_ldsel", {10'h0, ld6}, {10'h0, eld6(6'b100000)});
        cyc(1);
        check("n6_wrap", {15'h0, wrap6}, 16'h1);
        check("n6_p0_sseg", {8'h0, sseg6}, {8'h0, UP});
        check("n6_p0_ldsel", {10'h0, ld6}, {10'h0, eld6(6'b100000)});
        cyc(1);
        check("n6_wrap_clear", {15'h0, wrap6}, 16'h0);
        check("n6_p1_ldsel", {10'h0, ld6}, {10'h0, eld6(6'b010000)});

`ifdef ROTSQ_BRIGHTNESS_EN
        // Brightness: position held at p=6
        bright = 4'd4;
        cnt = 0;
        repeat (16) begin
            cyc(1);
            if (ld != 4'b0000) cnt++;
        end
        check("bright4_duty", cnt[15:0], 16'd4);
        bright = 4'd0;
        en = 1'b1;
        cnt = 0;
        repeat (16) begin
            cyc(1);
            if (ld != 4'b0000) cnt++;
        end
        check("bright0_blank", cnt[15:0], 16'd0);
        check("bright0_sseg_anim", {8'h0, sseg}, {8'h0, UP});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
